// File: rtl/sweep_pkg.sv
// Shared constants and FSM state encoding for the sweep sequencer.
package sweep_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CYC_W_DEF = 4;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN_FWD = 3'd2,
        ST_RUN_REV = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/sweep_ctrl_if.sv
// Command/status bundle between a host and sweep_ctrl.
// Carries the pause input only when SWEEP_PAUSE_EN is defined.
interface sweep_ctrl_if
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CYC_W = CYC_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_end;
    logic             cmd_pingpong;
    logic [CYC_W-1:0] cmd_cycles;
    logic             abort;
`ifdef SWEEP_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] q;
    logic             m;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
`ifdef SWEEP_PAUSE_EN
        output pause,
`endif
        output cmd_valid, cmd_start, cmd_end, cmd_pingpong, cmd_cycles, abort,
        input  cmd_ready, q, m, busy, done, aborted
    );

    modport slave (
`ifdef SWEEP_PAUSE_EN
        input  pause,
`endif
        input  cmd_valid, cmd_start, cmd_end, cmd_pingpong, cmd_cycles, abort,
        output cmd_ready, q, m, busy, done, aborted
    );

endinterface

// File: rtl/updown_cnt_core.sv
// Loadable up/down count register; priority rst > load > en.
module updown_cnt_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= d_i;
        end else if (en_i) begin
            cnt_q <= up_i ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequencer: single or ping-pong start/end sweeps over an up/down counter.
// Optional SWEEP_PAUSE_EN adds a pause input that freezes the RUN states.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CYC_W = CYC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sweep_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d, end_q, end_d;
    logic             pp_q, pp_d;
    logic [CYC_W-1:0] cyc_tgt_q, cyc_tgt_d, cyc_cnt_q, cyc_cnt_d;
    logic             m_q, m_d, done_q, done_d, aborted_q, aborted_d, busy_q, busy_d;

    logic             accept_c, pause_c, at_end_c, at_start_c, last_trip_c;
    logic             cnt_load_c, cnt_en_c, cnt_up_c;
    logic [CYC_W-1:0] cyc_inc_c;
    logic [WIDTH-1:0] q_w;

`ifdef SWEEP_PAUSE_EN
    assign pause_c = bus.pause;
`else
    assign pause_c = 1'b0;
`endif

    assign bus.cmd_ready = (state_q == ST_IDLE) && rst;
    assign accept_c      = bus.cmd_valid && bus.cmd_ready;
    assign at_end_c      = (q_w == end_q);
    assign at_start_c    = (q_w == start_q);
    assign cyc_inc_c     = cyc_cnt_q + CYC_W'(1);
    assign last_trip_c   = (cyc_inc_c == cyc_tgt_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks pause
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_LOAD;
            ST_LOAD: begin
                if (bus.abort)               state_d = ST_IDLE;
                else if (start_q == end_q)   state_d = ST_DONE;
                else                         state_d = ST_RUN_FWD;
            end
            ST_RUN_FWD: begin
                if (bus.abort)               state_d = ST_IDLE;
                else if (pause_c)            state_d = ST_RUN_FWD;
                else if (at_end_c)           state_d = pp_q ? ST_RUN_REV : ST_DONE;
            end
            ST_RUN_REV: begin
                if (bus.abort)               state_d = ST_IDLE;
                else if (pause_c)            state_d = ST_RUN_REV;
                else if (at_start_c)         state_d = last_trip_c ? ST_DONE : ST_RUN_FWD;
            end
            ST_DONE:                         state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // Datapath controls and next values of the registered outputs
    always_comb begin
        start_d    = start_q;
        end_d      = end_q;
        pp_d       = pp_q;
        cyc_tgt_d  = cyc_tgt_q;
        cyc_cnt_d  = cyc_cnt_q;
        m_d        = m_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        cnt_load_c = 1'b0;
        cnt_en_c   = 1'b0;
        cnt_up_c   = m_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    start_d   = bus.cmd_start;
                    end_d     = bus.cmd_end;
                    pp_d      = bus.cmd_pingpong;
                    cyc_tgt_d = (bus.cmd_cycles == '0) ? CYC_W'(1) : bus.cmd_cycles;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end else begin
                    cnt_load_c = 1'b1;
                    m_d        = (end_q >= start_q);
                    cyc_cnt_d  = '0;
                    done_d     = (start_q == end_q);
                end
            end
            ST_RUN_FWD: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end else if (!pause_c) begin
                    if (!at_end_c) begin
                        cnt_en_c = 1'b1;
                    end else if (pp_q) begin
                        m_d      = ~m_q;
                        cnt_en_c = 1'b1;
                        cnt_up_c = ~m_q;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN_REV: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end else if (!pause_c) begin
                    if (!at_start_c) begin
                        cnt_en_c = 1'b1;
                    end else begin
                        cyc_cnt_d = cyc_inc_c;
                        if (last_trip_c) begin
                            done_d = 1'b1;
                        end else begin
                            m_d      = ~m_q;
                            cnt_en_c = 1'b1;
                            cnt_up_c = ~m_q;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort) aborted_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q   <= '0;
            end_q     <= '0;
            pp_q      <= 1'b0;
            cyc_tgt_q <= '0;
            cyc_cnt_q <= '0;
            m_q       <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            start_q   <= start_d;
            end_q     <= end_d;
            pp_q      <= pp_d;
            cyc_tgt_q <= cyc_tgt_d;
            cyc_cnt_q <= cyc_cnt_d;
            m_q       <= m_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
        end
    end

    updown_cnt_core #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load_c),
        .d_i    (start_q),
        .en_i   (cnt_en_c),
        .up_i   (cnt_up_c),
        .q_o    (q_w)
    );

    assign bus.q       = q_w;
    assign bus.m       = m_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;

endmodule
